sorting_network_stream: RTL and testbench

//  Pipelined odd-even transposition sorter for one vector of NUMBERS_AMOUNT words per beat.

---
 rtl/sorting_network_stream.sv | 151 +++++++++++++++
 tb/tb_sorting_network_stream.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sorting_network_stream.sv
// Pipelined odd-even transposition sorter with valid/ready handshake and per-stage backpressure.
// Define SORT_INDEX_EN to add the idx_o port carrying each element's original position.
module sorting_network_stream #(
  parameter int unsigned NUMBER_WIDTH   = 10,
  parameter int unsigned NUMBERS_AMOUNT = 10,
  parameter bit          SIGNED_CMP     = 1'b0,
  parameter int unsigned IDX_WIDTH      = (NUMBERS_AMOUNT > 2) ? $clog2(NUMBERS_AMOUNT) : 1
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  input  logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0]    data_i,
  input  logic                                           desc_i,
  input  logic                                           valid_i,
  output logic                                           ready_o,
  output logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0]    data_o,
  output logic                                           desc_o,
  output logic                                           valid_o,
`ifdef SORT_INDEX_EN
  output logic [NUMBERS_AMOUNT-1:0][IDX_WIDTH-1:0]       idx_o,
`endif
  input  logic                                           ready_i
);

  localparam int unsigned N = NUMBERS_AMOUNT;
  localparam int unsigned L = NUMBERS_AMOUNT;
  localparam int unsigned W = NUMBER_WIDTH;

  typedef logic [N-1:0][W-1:0]         vec_t;
  typedef logic [N-1:0][IDX_WIDTH-1:0] idx_t;

  vec_t [L-1:0] vec_q, vec_d, src_vec, net_vec;
  logic [L-1:0] valid_q, valid_d, desc_q, desc_d;
  logic [L-1:0] src_valid, src_desc, load;

`ifdef SORT_INDEX_EN
  idx_t [L-1:0] idx_q, idx_d, src_idx, net_idx;
`endif

  // Strict compare in the requested direction: equal values never swap, keeping the sort stable.
  function automatic logic out_of_order(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic desc);
    logic a_gt_b, a_lt_b;
    if (SIGNED_CMP) begin
      a_gt_b = $signed(a) > $signed(b);
      a_lt_b = $signed(a) < $signed(b);
    end else begin
      a_gt_b = a > b;
      a_lt_b = a < b;
    end
    return desc ? a_lt_b : a_gt_b;
  endfunction

  // A stage may load if it, or any stage downstream of it, holds a bubble, or the sink is ready.
  always_comb begin
    logic any_room;
    load     = '0;
    any_room = ready_i;
    for (int k = int'(L) - 1; k >= 0; k--) begin
      any_room = any_room | ~valid_q[k];
      load[k]  = any_room;
    end
  end

  always_comb begin
    src_vec[0]   = data_i;
    src_valid[0] = valid_i;
    src_desc[0]  = desc_i;
    for (int k = 1; k < int'(L); k++) begin
      src_vec[k]   = vec_q[k-1];
      src_valid[k] = valid_q[k-1];
      src_desc[k]  = desc_q[k-1];
    end
  end

`ifdef SORT_INDEX_EN
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      src_idx[0][i] = IDX_WIDTH'(i);
    end
    for (int k = 1; k < int'(L); k++) begin
      src_idx[k] = idx_q[k-1];
    end
  end
`endif

  // Even layers pair (0,1),(2,3)..; odd layers pair (1,2),(3,4)..; an unpaired end passes through.
  always_comb begin
    net_vec = src_vec;
`ifdef SORT_INDEX_EN
    net_idx = src_idx;
`endif
    for (int k = 0; k < int'(L); k++) begin
      for (int j = k % 2; j + 1 < int'(N); j += 2) begin
        if (out_of_order(src_vec[k][j], src_vec[k][j+1], src_desc[k])) begin
          net_vec[k][j]   = src_vec[k][j+1];
          net_vec[k][j+1] = src_vec[k][j];
`ifdef SORT_INDEX_EN
          net_idx[k][j]   = src_idx[k][j+1];
          net_idx[k][j+1] = src_idx[k][j];
`endif
        end
      end
    end
  end

  always_comb begin
    vec_d   = vec_q;
    valid_d = valid_q;
    desc_d  = desc_q;
`ifdef SORT_INDEX_EN
    idx_d   = idx_q;
`endif
    for (int k = 0; k < int'(L); k++) begin
      if (load[k]) begin
        vec_d[k]   = net_vec[k];
        valid_d[k] = src_valid[k];
        desc_d[k]  = src_desc[k];
`ifdef SORT_INDEX_EN
        idx_d[k]   = net_idx[k];
`endif
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vec_q   <= '0;
      valid_q <= '0;
      desc_q  <= '0;
`ifdef SORT_INDEX_EN
      idx_q   <= '0;
`endif
    end else begin
      vec_q   <= vec_d;
      valid_q <= valid_d;
      desc_q  <= desc_d;
`ifdef SORT_INDEX_EN
      idx_q   <= idx_d;
`endif
    end
  end

  assign ready_o = load[0];
  assign data_o  = vec_q[L-1];
  assign desc_o  = desc_q[L-1];
  assign valid_o = valid_q[L-1];
`ifdef SORT_INDEX_EN
  assign idx_o   = idx_q[L-1];
`endif

endmodule

// File: tb/tb_sorting_network_stream.sv
// Self-checking bench for sorting_network_stream: stable-sort reference model plus directed vectors.
// Exercises idx_o as well when SORT_INDEX_EN is defined.
module tb_sorting_network_stream;

  localparam int N  = 10;
  localparam int W  = 10;
  localparam int IW = 4;

  typedef logic [N-1:0][W-1:0]  vec_t;
  typedef logic [N-1:0][IW-1:0] idx_t;
  typedef struct {
    vec_t d;
    logic desc;
    idx_t ix;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  vec_t data_i = '0;
  logic desc_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
  vec_t data_o;
  logic desc_o, valid_o, ready_o;
  idx_t idx_o;

  logic [3:0][7:0] s_data_i = '0;
  logic            s_valid_i = 1'b0, s_ready_i = 1'b0;
  logic [3:0][7:0] s_data_o;
  logic            s_desc_o, s_valid_o, s_ready_o;
`ifdef SORT_INDEX_EN
  logic [3:0][1:0] s_idx_o;
`endif

  always #5 clk_i = ~clk_i;

  sorting_network_stream #(
    .NUMBER_WIDTH  (W),
    .NUMBERS_AMOUNT(N),
    .SIGNED_CMP    (1'b0)
  ) u_dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .data_i (data_i),
    .desc_i (desc_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_o (data_o),
    .desc_o (desc_o),
    .valid_o(valid_o),
`ifdef SORT_INDEX_EN
    .idx_o  (idx_o),
`endif
    .ready_i(ready_i)
  );

`ifndef SORT_INDEX_EN
  assign idx_o = '0;
`endif

  sorting_network_stream #(
    .NUMBER_WIDTH  (8),
    .NUMBERS_AMOUNT(4),
    .SIGNED_CMP    (1'b1)
  ) u_sgn (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .data_i (s_data_i),
    .desc_i (1'b0),
    .valid_i(s_valid_i),
    .ready_o(s_ready_o),
    .data_o (s_data_o),
    .desc_o (s_desc_o),
    .valid_o(s_valid_o),
`ifdef SORT_INDEX_EN
    .idx_o  (s_idx_o),
`endif
    .ready_i(s_ready_i)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_pops  = 0;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference: stable insertion sort on (value, original index) pairs.
  function automatic exp_t model(input vec_t v, input logic d);
    int   val[N];
    int   id[N];
    int   t;
    exp_t e;
    for (int i = 0; i < N; i++) begin
      val[i] = int'(v[i]);
      id[i]  = i;
    end
    for (int i = 1; i < N; i++) begin
      for (int j = i; j > 0; j--) begin
        if (d ? (val[j-1] < val[j]) : (val[j-1] > val[j])) begin
          t = val[j]; val[j] = val[j-1]; val[j-1] = t;
          t = id[j];  id[j]  = id[j-1];  id[j-1]  = t;
        end else begin
          break;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      e.d[i]  = W'(val[i]);
      e.ix[i] = IW'(id[i]);
    end
    e.desc = d;
    return e;
  endfunction

  function automatic vec_t mk(input int a[N]);
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = W'(a[i]);
    return v;
  endfunction

  function automatic vec_t rnd_vec(input int maxv);
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = W'($urandom_range(0, maxv));
    return v;
  endfunction

  // Scoreboard: push on input handshake, pop and compare on output handshake, check holds.
  logic hold_pend = 1'b0;
  vec_t hold_d;
  logic hold_desc;
  always @(negedge clk_i) begin
    if (rst_i) begin
      exp_q.delete();
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("stall_hold", {valid_o, desc_o, data_o}, {1'b1, hold_desc, hold_d});
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          n_pops++;
          chk("beat_data", {desc_o, data_o}, {e.desc, e.d});
`ifdef SORT_INDEX_EN
          chk("beat_idx", idx_o, e.ix);
`endif
        end
      end
      hold_pend = valid_o && !ready_i;
      hold_d    = data_o;
      hold_desc = desc_o;
      if (valid_i && ready_o) exp_q.push_back(model(data_i, desc_i));
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Counts edges from the presentation of a single beat until valid_o rises.
  task automatic send_one(input vec_t v, input logic d, output int lat);
    data_i  = v;
    desc_i  = d;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int   arr[N];
    int   lat, first, beats, last, acc, rdy_low, stale;
    vec_t t1_in;
    idx_t t2_idx;

    #1;
    chk("reset_ready_o", ready_o, 1);
    chk("reset_valid_o", valid_o, 0);
    chk("reset_data_o", {desc_o, data_o}, 0);
    chk("reset_idx_o", idx_o, 0);
    tick();
    tick();
    rst_i   = 1'b0;
    ready_i = 1'b1;
    tick();

    // 1: ascending sort, 10-cycle latency, single beat
    arr   = '{9, 3, 7, 0, 1022, 5, 5, 2, 8, 1};
    t1_in = mk(arr);
    send_one(t1_in, 1'b0, lat);
    chk("t1_latency", lat, 10);
    arr = '{0, 1, 2, 3, 5, 5, 7, 8, 9, 1022};
    chk("t1_data", {desc_o, data_o}, {1'b0, mk(arr)});
    tick();
    chk("t1_one_beat", valid_o, 0);

    // 2: same vector descending; ties 5,5 keep original order 5,6
    send_one(t1_in, 1'b1, lat);
    arr = '{1022, 9, 8, 7, 5, 5, 3, 2, 1, 0};
    chk("t2_data", data_o, mk(arr));
    chk("t2_desc_o", desc_o, 1);
`ifdef SORT_INDEX_EN
    arr = '{4, 0, 8, 2, 5, 6, 1, 7, 9, 3};
    for (int i = 0; i < N; i++) t2_idx[i] = IW'(arr[i]);
    chk("t2_idx", idx_o, t2_idx);
`endif
    tick();

    // 3: 25 back-to-back vectors, consumer always ready
    first = -1; beats = 0; last = 0; rdy_low = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c <= 25) begin
        data_i  = rnd_vec((c % 3 == 0) ? 7 : 1023);
        desc_i  = 1'($urandom_range(0, 1));
        valid_i = 1'b1;
        rdy_low += int'(!ready_o);
      end else begin
        valid_i = 1'b0;
      end
      tick();
      if (valid_o) begin
        if (first < 0) first = c;
        beats++;
        last = c;
      end
    end
    chk("t3_ready_never_low", rdy_low, 0);
    chk("t3_first_beat", first, 10);
    chk("t3_beats", beats, 25);
    chk("t3_consecutive", last - first + 1, 25);

    // 4: downstream stalls 30 cycles with input always offered
    ready_i = 1'b0;
    acc = 0;
    for (int c = 0; c < 30; c++) begin
      data_i  = rnd_vec(1023);
      desc_i  = 1'($urandom_range(0, 1));
      valid_i = 1'b1;
      acc += int'(ready_o);
      tick();
    end
    chk("t4_accepted", acc, 10);
    chk("t4_ready_low", ready_o, 0);
    valid_i = 1'b0;
    ready_i = 1'b1;
    n_pops  = 0;
    for (int c = 0; c < 30 && exp_q.size() != 0; c++) tick();
    tick();
    chk("t4_drained", n_pops, 10);
    chk("t4_sb_empty", exp_q.size(), 0);

    // 5: signed compare, N=4 W=8
    s_data_i  = {8'h7F, 8'h80, 8'hFF, 8'h01};
    s_valid_i = 1'b1;
    s_ready_i = 1'b1;
    tick();
    s_valid_i = 1'b0;
    lat = 1;
    while (!s_valid_o && lat < 20) begin
      tick();
      lat++;
    end
    chk("t5_latency", lat, 4);
    chk("t5_data", s_data_o, {8'h7F, 8'h01, 8'hFF, 8'h80});
    tick();

    // 6: reset with 5 vectors in flight
    for (int c = 0; c < 5; c++) begin
      data_i  = rnd_vec(1023);
      desc_i  = 1'b0;
      valid_i = 1'b1;
      tick();
    end
    valid_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
    #1;
    chk("t6_valid_in_reset", valid_o, 0);
    chk("t6_ready_in_reset", ready_o, 1);
    tick();
    tick();
    rst_i = 1'b0;
    stale = 0;
    for (int c = 0; c < 14; c++) begin
      tick();
      stale += int'(valid_o);
    end
    chk("t6_no_stale", stale, 0);
    send_one(rnd_vec(1023), 1'b1, lat);
    chk("t6_latency", lat, 10);
    tick();
    tick();
    chk("final_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
